boid_position_updater: RTL

Per-frame integration engine for the boid accelerator. On each `start` pulse it walks every boid slot in the boid state memory (`register_test_mem_wrapper`) in index order. For each boid it reads the state, applies the accumulated acceleration to the velocity, clamps the speed, integrates the position and reflects off the screen edges. It then writes the new state back and clears the accumulators. It sits between the flocking-rule stage, which fills `vx_acc`/`vy_acc`, and the VGA scan stage, which reads positions through `is_boid_here`.

---
 rtl/boid_pkg.sv | 38 +++
 rtl/boid_position_updater_axis.sv | 34 +++
 rtl/boid_position_updater.sv | 136 +++++++++++++
 3 files changed

// File: rtl/boid_pkg.sv
// Shared types and fixed-point helpers for the boid
// position integration engine.
package boid_pkg;

  localparam int FRAC = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE,
    DONE
  } state_e;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] vx;
    logic signed [31:0] vy;
  } boid_t;

  // Clamp a 33-bit sum into [-limit, +limit].
  function automatic logic signed [31:0] fix_sat(
    input logic signed [32:0] value,
    input logic signed [31:0] limit
  );
    logic signed [32:0] lim;
    lim = {limit[31], limit};
    if (value > lim) begin
      fix_sat = limit;
    end else if (value < -lim) begin
      fix_sat = -limit;
    end else begin
      fix_sat = value[31:0];
    end
  endfunction

endpackage

// File: rtl/boid_position_updater_axis.sv
// One-axis velocity saturation, position integration
// and edge reflection; purely combinational.
module boid_axis_update
  import boid_pkg::*;
(
  input  logic signed [31:0] p,
  input  logic signed [31:0] v,
  input  logic signed [31:0] acc,
  input  logic signed [31:0] max,
  input  logic signed [31:0] v_max,
  output logic signed [31:0] p_new,
  output logic signed [31:0] v_new
);

  logic signed [32:0] sum;
  logic signed [31:0] v_sat;
  logic signed [32:0] pos;

  always_comb begin
    sum   = {v[31], v} + {acc[31], acc};
    v_sat = fix_sat(sum, v_max);
    pos   = {p[31], p} + {v_sat[31], v_sat};
    p_new = pos[31:0];
    v_new = v_sat;
    if (pos < 33'sd0) begin
      p_new = '0;
      v_new = -v_sat;
    end else if (pos > {max[31], max}) begin
      p_new = max;
      v_new = -v_sat;
    end
  end

endmodule

// File: rtl/boid_position_updater.sv
// Frame update sequencer: load, integrate and write
// back every boid slot in index order.
module boid_position_updater
  import boid_pkg::*;
#(
  parameter int num_boids = 2,
  parameter int x_max     = 639,
  parameter int y_max     = 479,
  parameter int v_max     = 6,
  localparam int IW = (num_boids > 1) ? $clog2(num_boids) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] which_boid,
  output logic [6:0]    wb_en,
  input  logic [31:0]   x_in_32,
  input  logic [31:0]   y_in_32,
  input  logic [31:0]   vx_in_32,
  input  logic [31:0]   vy_in_32,
  input  logic [31:0]   vx_acc_in,
  input  logic [31:0]   vy_acc_in,
  output logic [31:0]   x_out_32,
  output logic [31:0]   y_out_32,
  output logic [31:0]   vx_out_32,
  output logic [31:0]   vy_out_32,
  output logic [31:0]   vx_acc_out,
  output logic [31:0]   vy_acc_out
);

  localparam logic signed [31:0] X_LIM =
    32'(x_max * (1 << FRAC));
  localparam logic signed [31:0] Y_LIM =
    32'(y_max * (1 << FRAC));
  localparam logic signed [31:0] V_LIM =
    32'(v_max * (1 << FRAC));
  localparam logic [IW-1:0] LAST = IW'(num_boids - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  boid_t              ld_q, ld_d;
  logic signed [31:0] ax_q, ax_d;
  logic signed [31:0] ay_q, ay_d;
  boid_t              res_q, res_d;

  logic signed [31:0] nx, nvx, ny, nvy;

  boid_axis_update u_x (
    .p     (ld_q.x),
    .v     (ld_q.vx),
    .acc   (ax_q),
    .max   (X_LIM),
    .v_max (V_LIM),
    .p_new (nx),
    .v_new (nvx)
  );

  boid_axis_update u_y (
    .p     (ld_q.y),
    .v     (ld_q.vy),
    .acc   (ay_q),
    .max   (Y_LIM),
    .v_max (V_LIM),
    .p_new (ny),
    .v_new (nvy)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld_d    = ld_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    res_d   = res_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      (state_q == LOAD): begin
        ld_d    = '{x_in_32, y_in_32,
                    vx_in_32, vy_in_32};
        ax_d    = vx_acc_in;
        ay_d    = vy_acc_in;
        state_d = CALC;
      end
      (state_q == CALC): begin
        res_d   = '{nx, ny, nvx, nvy};
        state_d = WRITE;
      end
      (state_q == WRITE): begin
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ld_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ld_q    <= ld_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      res_q   <= res_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign wb_en      = (state_q == WRITE) ? 7'h7F : 7'h00;
  assign which_boid = idx_q;
  assign x_out_32   = res_q.x;
  assign y_out_32   = res_q.y;
  assign vx_out_32  = res_q.vx;
  assign vy_out_32  = res_q.vy;
  assign vx_acc_out = '0;
  assign vy_acc_out = '0;

endmodule
